// File: rtl/sram_buffer.sv
// sram_buffer: single-port SRAM with registered read data, output-enable gating
// and a self-initialising clear sweep after reset or on request.
module sram_buffer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  clear,
   input  logic                  output_enable,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  read_valid,
   output logic                  busy,
   output logic                  req_dropped
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   typedef enum logic {CLEAR, IDLE} state_t;
   state_t                  state;
   logic [ADDR_WIDTH-1:0]   ptr;
   logic [DATA_WIDTH-1:0]   rd_reg;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   assign busy     = state == CLEAR;
   assign out_data = output_enable ? rd_reg : '0;
   // Array has no reset; the post-reset sweep initialises it.
   always_ff @(posedge clk)
      if (state == CLEAR) mem[ptr] <= CLEAR_VALUE;
      else if (write_enable) mem[addr] <= in_data;
   always_ff @(posedge clk or negedge n_rst)
      if (!n_rst) begin
         state       <= CLEAR;
         ptr         <= '0;
         rd_reg      <= '0;
         read_valid  <= 1'b0;
         req_dropped <= 1'b0;
      end else if (state == CLEAR) begin
         read_valid  <= 1'b0;
         req_dropped <= read_enable | write_enable | clear;
         ptr         <= ptr + 1'b1;
         if (&ptr) state <= IDLE;
      end else begin
         read_valid  <= read_enable;
         req_dropped <= 1'b0;
         if (read_enable) rd_reg <= mem[addr];
         if (clear) begin
            state <= CLEAR;
            ptr   <= '0;
         end
      end
endmodule

// File: tb/tb_sram_buffer.sv
// tb_sram_buffer: directed tests for sram_buffer with CLEAR_VALUE 0x00 and 0xFF.
module tb_sram_buffer;
   logic       clk = 0, n_rst = 0, write_enable = 0, read_enable = 0, clear = 0, output_enable = 0;
   logic [3:0] addr = 0;
   logic [7:0] in_data = 0;
   logic [7:0] out0, out1;
   logic       rv0, rv1, busy0, busy1, dr0, dr1;
   int         total = 0, bad = 0;

   always #5 clk = ~clk;

   sram_buffer u0 (.clk(clk), .n_rst(n_rst), .write_enable(write_enable), .read_enable(read_enable),
      .addr(addr), .in_data(in_data), .clear(clear), .output_enable(output_enable),
      .out_data(out0), .read_valid(rv0), .busy(busy0), .req_dropped(dr0));
   sram_buffer #(.CLEAR_VALUE(8'hFF)) u1 (.clk(clk), .n_rst(n_rst), .write_enable(write_enable),
      .read_enable(read_enable), .addr(addr), .in_data(in_data), .clear(clear),
      .output_enable(output_enable), .out_data(out1), .read_valid(rv1), .busy(busy1),
      .req_dropped(dr1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      addr = a; in_data = d; write_enable = 1;
      tick;
      write_enable = 0;
   endtask

   task automatic count_busy(input string name);
      int cnt = 0;
      while (busy0 && cnt < 40) begin
         tick;
         cnt++;
      end
      total++;
      if (cnt !== 16 || busy1 !== 1'b0) begin
         bad++;
         $display("FAIL %s busy_edges got=%0d exp=16 busy1=%b", name, cnt, busy1);
      end
   endtask

   task automatic read_all(input string name, input logic [7:0] e0, input logic [7:0] e1);
      output_enable = 1;
      for (int a = 0; a < 16; a++) begin
         addr = 4'(a); read_enable = 1;
         tick;
         total++;
         if (out0 !== e0 || out1 !== e1 || rv0 !== 1'b1) begin
            bad++;
            $display("FAIL %s addr=%0d got=%h/%h rv=%b exp=%h/%h rv=1", name, a, out0, out1, rv0, e0, e1);
         end
      end
      read_enable = 0;
   endtask

   task automatic test_reset;
      output_enable = 1;
      repeat (3) tick;
      total++;
      if (busy0 !== 1 || rv0 !== 0 || dr0 !== 0 || out0 !== 8'h00) begin
         bad++;
         $display("FAIL reset_state got busy=%b rv=%b dr=%b out=%h exp 1 0 0 00", busy0, rv0, dr0, out0);
      end
      output_enable = 0;
      n_rst = 1;
      count_busy("reset_sweep");
      total++;
      if (out0 !== 8'h00) begin
         bad++;
         $display("FAIL reset_oe0 got=%h exp=00", out0);
      end
      read_all("reset_read", 8'h00, 8'hFF);
   endtask

   task automatic test_output_enable;
      wr(4'd3, 8'h2A);
      addr = 3; read_enable = 1; output_enable = 1;
      tick;
      read_enable = 0;
      total++;
      if (rv0 !== 1 || out0 !== 8'h2A) begin
         bad++;
         $display("FAIL oe_read got rv=%b out=%h exp rv=1 out=2a", rv0, out0);
      end
      tick;
      total++;
      if (rv0 !== 0) begin
         bad++;
         $display("FAIL oe_pulse got rv=%b exp=0", rv0);
      end
      output_enable = 0;
      #1;
      total++;
      if (out0 !== 8'h00) begin
         bad++;
         $display("FAIL oe_low got=%h exp=00", out0);
      end
      output_enable = 1;
      tick;
      total++;
      if (out0 !== 8'h2A) begin
         bad++;
         $display("FAIL oe_hold got=%h exp=2a", out0);
      end
   endtask

   task automatic test_rbw;
      wr(4'd7, 8'h55);
      addr = 7; in_data = 8'hAA; read_enable = 1; write_enable = 1;
      tick;
      write_enable = 0;
      total++;
      if (out0 !== 8'h55) begin
         bad++;
         $display("FAIL rbw_old got=%h exp=55", out0);
      end
      tick;
      read_enable = 0;
      total++;
      if (out0 !== 8'hAA || rv0 !== 1) begin
         bad++;
         $display("FAIL rbw_new got=%h rv=%b exp=aa rv=1", out0, rv0);
      end
   endtask

   task automatic test_clear;
      for (int a = 0; a < 16; a++) wr(4'(a), 8'(a + 16));
      addr = 9; read_enable = 1; output_enable = 1;
      tick;
      read_enable = 0;
      total++;
      if (out1 !== 8'h19) begin
         bad++;
         $display("FAIL fill_read got=%h exp=19", out1);
      end
      clear = 1;
      tick;
      clear = 0;
      total++;
      if (busy1 !== 1) begin
         bad++;
         $display("FAIL clear_busy got=%b exp=1", busy1);
      end
      for (int i = 1; i <= 16; i++) begin
         if (i == 5) begin
            addr = 5; in_data = 8'h77; write_enable = 1; clear = 1; read_enable = 1;
         end
         tick;
         write_enable = 0; clear = 0; read_enable = 0;
         if (i == 5) begin
            total++;
            if (dr1 !== 1 || rv1 !== 0) begin
               bad++;
               $display("FAIL drop_pulse got dr=%b rv=%b exp dr=1 rv=0", dr1, rv1);
            end
         end
         if (i == 6) begin
            total++;
            if (dr1 !== 0) begin
               bad++;
               $display("FAIL drop_once got=%b exp=0", dr1);
            end
         end
         total++;
         if (busy1 !== (i < 16)) begin
            bad++;
            $display("FAIL clear_len cycle=%0d got=%b exp=%b", i, busy1, i < 16);
         end
      end
      total++;
      if (out1 !== 8'h19) begin
         bad++;
         $display("FAIL clear_keeps_rd got=%h exp=19", out1);
      end
      read_all("clear_read", 8'h00, 8'hFF);
   endtask

   task automatic test_reset_mid;
      clear = 1;
      tick;
      clear = 0;
      repeat (8) tick;
      n_rst = 0;
      #1;
      total++;
      if (busy1 !== 1 || rv1 !== 0 || dr1 !== 0 || out1 !== 8'h00) begin
         bad++;
         $display("FAIL midreset_state got busy=%b rv=%b dr=%b out=%h exp 1 0 0 00", busy1, rv1, dr1, out1);
      end
      #2 n_rst = 1;
      count_busy("midreset_sweep");
      read_all("midreset_read", 8'h00, 8'hFF);
   endtask

   task automatic test_back_to_back;
      wr(4'd0, 8'h11);
      wr(4'd1, 8'h22);
      wr(4'd2, 8'h33);
      output_enable = 1; read_enable = 1;
      for (int a = 0; a < 3; a++) begin
         addr = 4'(a);
         tick;
         total++;
         if (out0 !== 8'(8'h11 * (a + 1)) || rv0 !== 1) begin
            bad++;
            $display("FAIL b2b addr=%0d got=%h rv=%b exp=%h rv=1", a, out0, rv0, 8'(8'h11 * (a + 1)));
         end
      end
      read_enable = 0;
      tick;
      total++;
      if (rv0 !== 0 || out0 !== 8'h33) begin
         bad++;
         $display("FAIL b2b_end got rv=%b out=%h exp rv=0 out=33", rv0, out0);
      end
   endtask

   initial begin
      test_reset;
      test_output_enable;
      test_rbw;
      test_clear;
      test_reset_mid;
      test_back_to_back;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
